// File: rtl/msb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | msb_ctrl: URAM slice controller, STREAMS circular FIFO segments with a   |
// | round-robin read port and a stream-tagged read-latency pipe.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module msb_ctrl #(
  parameter int LINE_WIDTH = 512,
  parameter int RAM_DEPTH  = 4096,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int STREAMS    = 4,
  parameter int SID_WIDTH  = $clog2(STREAMS),
  parameter int SEG_DEPTH  = RAM_DEPTH / STREAMS,
  parameter int PTR_WIDTH  = ADDR_WIDTH - SID_WIDTH,
  parameter int RD_LAT     = 2
) (
  input  logic                             clk2x,
  input  logic                             reset_n,
  input  logic                             i_wr_v,
  input  logic [SID_WIDTH-1:0]             i_wr_sid,
  input  logic [LINE_WIDTH-1:0]            i_wr_d,
  output logic                             o_wr_r,
  input  logic [STREAMS-1:0]               i_flush,
  input  logic [STREAMS-1:0]               i_rd_req,
  output logic [STREAMS-1:0]               o_rd_gnt,
  output logic                             o_rd_v,
  output logic [SID_WIDTH-1:0]             o_rd_sid,
  output logic [LINE_WIDTH-1:0]            o_rd_d,
  output logic [STREAMS*(PTR_WIDTH+1)-1:0] o_count,
  output logic                             o_ram_we,
  output logic [ADDR_WIDTH-1:0]            o_ram_wa,
  output logic [LINE_WIDTH-1:0]            o_ram_wd,
  output logic                             o_ram_re,
  output logic [ADDR_WIDTH-1:0]            o_ram_ra,
  input  logic [LINE_WIDTH-1:0]            i_ram_rd
);

  localparam logic [PTR_WIDTH:0] c_seg_full = (PTR_WIDTH+1)'(SEG_DEPTH);

  logic [PTR_WIDTH-1:0] r_wptr  [STREAMS];
  logic [PTR_WIDTH-1:0] r_rptr  [STREAMS];
  logic [PTR_WIDTH:0]   r_count [STREAMS];
  logic [SID_WIDTH-1:0] r_rr;

  logic                 r_pipe_v   [RD_LAT];
  logic [SID_WIDTH-1:0] r_pipe_sid [RD_LAT];

  logic                 w_wr_acc;
  logic [STREAMS-1:0]   w_elig;
  logic                 w_any;
  logic [SID_WIDTH-1:0] w_win;
  logic [STREAMS-1:0]   w_inc;
  logic [STREAMS-1:0]   w_dec;

  assign o_wr_r   = (r_count[i_wr_sid] != c_seg_full) && !i_flush[i_wr_sid];
  assign w_wr_acc = i_wr_v && o_wr_r;

  // Eligibility sees the registered count, so a fresh write is readable one cycle later.
  for (genvar s = 0; s < STREAMS; s++) begin : g_stream
    assign w_elig[s] = i_rd_req[s] && (r_count[s] != '0) && !i_flush[s];
    assign o_count[s*(PTR_WIDTH+1) +: (PTR_WIDTH+1)] = r_count[s];
  end

  // Round-robin: scan downward so the closest eligible stream at/after r_rr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = STREAMS - 1; k >= 0; k--) begin
      if (w_elig[r_rr + SID_WIDTH'(k)]) begin
        w_any = 1'b1;
        w_win = r_rr + SID_WIDTH'(k);
      end
    end
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_wr_acc) w_inc[i_wr_sid] = 1'b1;
    if (w_any)    w_dec[w_win]    = 1'b1;
  end

  always_ff @(posedge clk2x or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < STREAMS; s++) begin
        r_wptr[s]  <= '0;
        r_rptr[s]  <= '0;
        r_count[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STREAMS; s++) begin
        if (i_flush[s]) begin
          r_wptr[s]  <= '0;
          r_rptr[s]  <= '0;
          r_count[s] <= '0;
        end else begin
          if (w_inc[s]) r_wptr[s] <= r_wptr[s] + 1'b1;
          if (w_dec[s]) r_rptr[s] <= r_rptr[s] + 1'b1;
          if (w_inc[s] && !w_dec[s])
            r_count[s] <= r_count[s] + 1'b1;
          else if (!w_inc[s] && w_dec[s])
            r_count[s] <= r_count[s] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk2x or negedge reset_n) begin
    if (!reset_n) begin
      o_ram_we <= 1'b0;
      o_ram_wa <= '0;
      o_ram_wd <= '0;
      o_ram_re <= 1'b0;
      o_ram_ra <= '0;
      o_rd_gnt <= '0;
      r_rr     <= '0;
    end else begin
      o_ram_we <= w_wr_acc;
      if (w_wr_acc) begin
        o_ram_wa <= {i_wr_sid, r_wptr[i_wr_sid]};
        o_ram_wd <= i_wr_d;
      end
      o_ram_re <= w_any;
      o_rd_gnt <= w_any ? (STREAMS'(1) << w_win) : '0;
      if (w_any) begin
        o_ram_ra <= {w_win, r_rptr[w_win]};
        r_rr     <= w_win + SID_WIDTH'(1);
      end
    end
  end

  // Stage 0 captures the read issued this cycle; the last stage lines up with i_ram_rd.
  always_ff @(posedge clk2x or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe_v[i]   <= 1'b0;
        r_pipe_sid[i] <= '0;
      end
    end else begin
      r_pipe_v[0]   <= o_ram_re;
      r_pipe_sid[0] <= o_ram_re ? o_ram_ra[ADDR_WIDTH-1 -: SID_WIDTH] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_sid[i] <= r_pipe_sid[i-1];
      end
    end
  end

  assign o_rd_v   = r_pipe_v[RD_LAT-1];
  assign o_rd_sid = r_pipe_sid[RD_LAT-1];
  assign o_rd_d   = i_ram_rd;

endmodule
`default_nettype wire

// File: tb/tb_msb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_msb_ctrl: directed self-checking bench for msb_ctrl with a 2-cycle    |
// | RAM model. Revision: 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_msb_ctrl;

  localparam int LW = 32;

  logic          clk2x = 1'b0;
  logic          reset_n;
  logic          i_wr_v;
  logic [1:0]    i_wr_sid;
  logic [LW-1:0] i_wr_d;
  logic          o_wr_r;
  logic [3:0]    i_flush;
  logic [3:0]    i_rd_req;
  logic [3:0]    o_rd_gnt;
  logic          o_rd_v;
  logic [1:0]    o_rd_sid;
  logic [LW-1:0] o_rd_d;
  logic [11:0]   o_count;
  logic          o_ram_we;
  logic [3:0]    o_ram_wa;
  logic [LW-1:0] o_ram_wd;
  logic          o_ram_re;
  logic [3:0]    o_ram_ra;
  logic [LW-1:0] i_ram_rd;

  int n_cmp = 0;
  int n_bad = 0;

  msb_ctrl #(
    .LINE_WIDTH(LW), .RAM_DEPTH(16), .STREAMS(4), .RD_LAT(2)
  ) dut (
    .clk2x(clk2x), .reset_n(reset_n),
    .i_wr_v(i_wr_v), .i_wr_sid(i_wr_sid), .i_wr_d(i_wr_d), .o_wr_r(o_wr_r),
    .i_flush(i_flush), .i_rd_req(i_rd_req), .o_rd_gnt(o_rd_gnt),
    .o_rd_v(o_rd_v), .o_rd_sid(o_rd_sid), .o_rd_d(o_rd_d), .o_count(o_count),
    .o_ram_we(o_ram_we), .o_ram_wa(o_ram_wa), .o_ram_wd(o_ram_wd),
    .o_ram_re(o_ram_re), .o_ram_ra(o_ram_ra), .i_ram_rd(i_ram_rd)
  );

  always #5 clk2x = ~clk2x;

  // RAM model: read data appears two cycles after the read address.
  logic [LW-1:0] mem [16];
  logic [LW-1:0] r_p1;
  always @(posedge clk2x) begin
    if (o_ram_we) mem[o_ram_wa] <= o_ram_wd;
    r_p1     <= mem[o_ram_ra];
    i_ram_rd <= r_p1;
  end

  task automatic tick();
    @(posedge clk2x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cnt(input int s);
    return o_count[s*3 +: 3];
  endfunction

  logic [1:0] t3_sid [7] = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [3:0] exp_gnt;

  initial begin
    reset_n = 1'b0; i_wr_v = 1'b0; i_wr_sid = '0; i_wr_d = '0;
    i_flush = '0; i_rd_req = '0;
    tick(); tick();
    chk("rst_gnt", o_rd_gnt, 0);
    chk("rst_rd_v", o_rd_v, 0);
    chk("rst_we", o_ram_we, 0);
    chk("rst_re", o_ram_re, 0);
    chk("rst_count", o_count, 0);
    chk("rst_wa", o_ram_wa, 0);
    chk("rst_ra", o_ram_ra, 0);
    reset_n = 1'b1;
    tick();

    // Two lines to stream 2, then drain them.
    i_wr_v = 1; i_wr_sid = 2; i_wr_d = 32'hA000_000A; #1;
    chk("t1_wr_r", o_wr_r, 1);
    tick();
    chk("t1_we", o_ram_we, 1); chk("t1_wa_a", o_ram_wa, 8); chk("t1_wd_a", o_ram_wd, 32'hA000_000A);
    i_wr_d = 32'hB000_000B;
    tick();
    chk("t1_wa_b", o_ram_wa, 9); chk("t1_wd_b", o_ram_wd, 32'hB000_000B); chk("t1_cnt2", cnt(2), 2);
    i_wr_v = 0; i_rd_req = 4'b0100;
    tick();
    chk("t1_gnt_a", o_rd_gnt, 4'b0100); chk("t1_re", o_ram_re, 1); chk("t1_ra_a", o_ram_ra, 8);
    chk("t1_cnt2_1", cnt(2), 1); chk("t1_rdv_0", o_rd_v, 0);
    tick();
    chk("t1_gnt_b", o_rd_gnt, 4'b0100); chk("t1_ra_b", o_ram_ra, 9); chk("t1_cnt2_0", cnt(2), 0);
    tick();
    chk("t1_gnt_off", o_rd_gnt, 0); chk("t1_re_off", o_ram_re, 0);
    chk("t1_rdv_a", o_rd_v, 1); chk("t1_sid_a", o_rd_sid, 2); chk("t1_d_a", o_rd_d, 32'hA000_000A);
    i_rd_req = 0;
    tick();
    chk("t1_rdv_b", o_rd_v, 1); chk("t1_d_b", o_rd_d, 32'hB000_000B);
    tick();
    chk("t1_rdv_end", o_rd_v, 0);

    // Fill stream 1, check full, read one, wrap a fifth write.
    i_wr_v = 1; i_wr_sid = 1;
    for (int i = 0; i < 4; i++) begin
      i_wr_d = 32'hC000_0000 + i;
      tick();
    end
    chk("t2_wa_last", o_ram_wa, 7); chk("t2_cnt1_full", cnt(1), 4);
    i_wr_v = 0; #1;
    chk("t2_full_rdy", o_wr_r, 0);
    i_wr_sid = 0; #1;
    chk("t2_other_rdy", o_wr_r, 1);
    i_rd_req = 4'b0010;
    tick();
    chk("t2_gnt", o_rd_gnt, 4'b0010); chk("t2_ra", o_ram_ra, 4); chk("t2_cnt1_3", cnt(1), 3);
    i_rd_req = 0; i_wr_v = 1; i_wr_sid = 1; i_wr_d = 32'hD000_0005;
    tick();
    chk("t2_wrap_we", o_ram_we, 1); chk("t2_wrap_wa", o_ram_wa, 4); chk("t2_cnt1_4", cnt(1), 4);
    i_wr_v = 0;
    tick();
    chk("t2_rdv", o_rd_v, 1); chk("t2_sid", o_rd_sid, 1); chk("t2_d", o_rd_d, 32'hC000_0000);
    i_flush = 4'b0010;
    tick();
    chk("t2_flush_cnt", cnt(1), 0);
    i_flush = 0;

    // Write and request an empty stream 3 in the same cycle.
    i_wr_v = 1; i_wr_sid = 3; i_wr_d = 32'hE000_0000; i_rd_req = 4'b1000;
    tick();
    chk("t4_nogrant", o_rd_gnt, 0); chk("t4_cnt3_1", cnt(3), 1);
    i_wr_d = 32'hE000_0001;
    tick();
    chk("t4_grant", o_rd_gnt, 4'b1000); chk("t4_ra", o_ram_ra, 12); chk("t4_cnt_same", cnt(3), 1);
    i_wr_v = 0; i_rd_req = 0;
    tick();
    chk("t4_gnt_off", o_rd_gnt, 0); chk("t4_cnt3_hold", cnt(3), 1);
    tick();
    chk("t4_rdv", o_rd_v, 1); chk("t4_sid", o_rd_sid, 3); chk("t4_d", o_rd_d, 32'hE000_0000);

    // Two lines in every stream, then a round-robin sweep.
    for (int i = 0; i < 7; i++) begin
      i_wr_v = 1; i_wr_sid = t3_sid[i]; i_wr_d = 32'h3000_0000 + i;
      tick();
    end
    i_wr_v = 0;
    chk("t3_counts", o_count, 12'h492);
    i_rd_req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_gnt = 4'b0001 << (i % 4);
      chk("t3_rr_gnt", o_rd_gnt, exp_gnt);
    end
    tick();
    chk("t3_gnt_idle", o_rd_gnt, 0); chk("t3_counts_0", o_count, 0);
    i_rd_req = 0;

    // Flush stream 0 with a read in flight and a concurrent write.
    i_wr_v = 1; i_wr_sid = 0; i_wr_d = 32'hF000_0000;
    tick();
    i_wr_d = 32'hF000_0001;
    tick();
    i_wr_v = 0; i_rd_req = 4'b0001;
    tick();
    chk("t5_gnt", o_rd_gnt, 4'b0001); chk("t5_cnt0_1", cnt(0), 1);
    i_rd_req = 0; i_flush = 4'b0001; i_wr_v = 1; i_wr_sid = 0; i_wr_d = 32'hF000_0002; #1;
    chk("t5_flush_rdy", o_wr_r, 0);
    tick();
    chk("t5_cnt0_0", cnt(0), 0); chk("t5_no_we", o_ram_we, 0);
    i_flush = 0; i_wr_v = 0;
    tick();
    chk("t5_rdv", o_rd_v, 1); chk("t5_sid", o_rd_sid, 0); chk("t5_d", o_rd_d, 32'hF000_0000);
    tick();
    chk("t5_cnt0_end", cnt(0), 0);

    // Reset with reads in flight.
    i_wr_v = 1; i_wr_sid = 2; i_wr_d = 32'h6000_0000;
    tick();
    i_wr_d = 32'h6000_0001;
    tick();
    i_wr_v = 0; i_rd_req = 4'b0100;
    tick(); tick();
    chk("t6_re_pre", o_ram_re, 1);
    reset_n = 0; i_rd_req = 0; #1;
    chk("t6_gnt", o_rd_gnt, 0); chk("t6_re", o_ram_re, 0); chk("t6_rdv", o_rd_v, 0);
    chk("t6_we", o_ram_we, 0); chk("t6_count", o_count, 0); chk("t6_sid", o_rd_sid, 0);
    tick();
    reset_n = 1; #1;
    chk("t6_wr_r", o_wr_r, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_rdv", o_rd_v, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
